// File: rtl/muldiv_unit_if.sv
// Start/done handshake, operands and results for muldiv_unit.
// The uns line exists only when MULDIV_UNSIGNED_EN is defined.
interface muldiv_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef MULDIV_UNSIGNED_EN
   logic             uns;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;

   modport master (
`ifdef MULDIV_UNSIGNED_EN
      output uns,
`endif
      output start, op, a, b,
      input  busy, done, hi, lo, div_zero
   );

   modport slave (
`ifdef MULDIV_UNSIGNED_EN
      input  uns,
`endif
      input  start, op, a, b,
      output busy, done, hi, lo, div_zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit, WIDTH+1 cycle latency.
// Optional unsigned mode (multu/divu) enabled by defining MULDIV_UNSIGNED_EN.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   muldiv_unit_if.slave  bus
);
   localparam int unsigned W2 = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             op_q, op_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;

   logic             uns_s;
   logic             sign_a, sign_b, b_zero;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shv, div_diff;
   logic [W2-1:0]    prod_neg;
   logic [WIDTH-1:0] quo_neg, rem_neg;

`ifdef MULDIV_UNSIGNED_EN
   assign uns_s = bus.uns;
`else
   assign uns_s = 1'b0;
`endif

   // Operand magnitudes and iteration arithmetic
   always_comb begin
      sign_a   = ~uns_s & bus.a[WIDTH-1];
      sign_b   = ~uns_s & bus.b[WIDTH-1];
      b_zero   = (bus.b == '0);
      mag_a    = sign_a ? (~bus.a + WIDTH'(1)) : bus.a;
      mag_b    = sign_b ? (~bus.b + WIDTH'(1)) : bus.b;
      mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_shv  = acc_q[W2-1:WIDTH-1];
      div_diff = div_shv - {1'b0, opnd_q};
      prod_neg = ~acc_q + W2'(1);
      quo_neg  = ~acc_q[WIDTH-1:0] + WIDTH'(1);
      rem_neg  = ~acc_q[W2-1:WIDTH] + WIDTH'(1);
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = (bus.op && b_zero) ? S_FIN : S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_FIN;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      cnt_d      = cnt_q;
      op_d       = op_q;
      neg_d      = neg_q;
      rneg_d     = rneg_q;
      opnd_d     = opnd_q;
      acc_d      = acc_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;
      busy_d     = (state_d != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d       = bus.op;
               neg_d      = sign_a ^ sign_b;
               rneg_d     = sign_a;
               cnt_d      = '0;
               div_zero_d = bus.op & b_zero;
               opnd_d     = bus.op ? mag_b : mag_a;
               acc_d      = {{WIDTH{1'b0}}, (bus.op ? mag_a : mag_b)};
            end
         end
         S_RUN: begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
            if (!op_q) begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end else if (!div_diff[WIDTH]) begin
               acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {div_shv[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
         end
         S_FIN: begin
            done_d = 1'b1;
            // A divide-by-zero leaves the previous result visible
            if (!div_zero_q) begin
               if (!op_q) begin
                  {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
               end else begin
                  hi_d = rneg_q ? rem_neg : acc_q[W2-1:WIDTH];
                  lo_d = neg_q ? quo_neg : acc_q[WIDTH-1:0];
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         op_q       <= 1'b0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         opnd_q     <= '0;
         acc_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         neg_q      <= neg_d;
         rneg_q     <= rneg_d;
         opnd_q     <= opnd_d;
         acc_q      <= acc_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.div_zero = div_zero_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative signed multiply/divide unit with a start/done handshake, WIDTH-bit operands, and divide-by-zero detection. It replaces the fixed 32-bit multiplier and provides the missing divider behind the HI/LO registers. The control unit pulses `start`, waits for `done`, then loads `hi`/`lo` into HI and LO. It sits beside the ALU and is fed from the A and B operand registers.

## Interface
- `WIDTH`, default 32, operand width in bits; minimum 4.
- `CNT_W`, default `$clog2(WIDTH+1)`, width of the iteration counter; derived, do not override.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; the only reset.
- `start`  in  1  request; sampled only while `busy`=0.
- `op`  in  1  0 = multiply, 1 = divide; sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend; sampled with `start`.
- `b`  in  WIDTH  multiplier / divisor; sampled with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `hi`/`lo` valid from this cycle onward.
- `hi`  out  WIDTH  product upper half / remainder.
- `lo`  out  WIDTH  product lower half / quotient.
- `div_zero`  out  1  last accepted operation was a divide with `b`=0.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: WIDTH iterations.
  - FIN: sign correction and result write.
- IDLE -> RUN on `start`=1:
  - Latches `a`, `b` and `op`.
  - Clears the counter and clears `div_zero`.
- IDLE -> FIN directly when `start`=1, `op`=1 and `b`=0:
  - Sets `div_zero`=1.
  - `hi`/`lo` keep their previous values.
- RUN:
  - One iteration per clock; counter increments.
  - Moves to FIN on the edge that completes iteration WIDTH.
- FIN -> IDLE: writes `hi`/`lo` (except for divide-by-zero) and asserts `done` for one cycle.
- Multiply:
  - `{hi,lo}` = exact signed 2·WIDTH-bit product of `a`·`b`.
  - Internally: magnitude shift-add, then two's-complement negate in FIN if the operand signs differ.
- Divide:
  - Restoring division on magnitudes, one quotient bit per iteration.
  - `lo` = quotient truncated toward zero; `hi` = remainder, carrying the sign of the dividend.
  - Most-negative ÷ −1: `lo` = most-negative value (wraps), `hi` = 0, no flag.
- `start` while `busy`=1 is ignored; operands are not resampled.
- `div_zero` holds its value until the next accepted `start`.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - State IDLE, counter 0.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_zero`=0.
  - The in-flight operation is discarded.
- Normal operation, with `start` accepted at edge E:
  - `busy`=1 from edge E until edge E+WIDTH+1.
  - `hi`/`lo` update, `done`=1 and `busy`=0 at edge E+WIDTH+1.
  - Latency: WIDTH+1 cycles for both multiply and divide.
- Divide-by-zero accepted at edge E:
  - `busy`=1 for one cycle.
  - `done`=1 and `div_zero`=1 at edge E+1.
- `done` is a registered pulse that falls at the next edge.
- A new `start` is accepted in the same cycle `done`=1 (back-to-back, no bubble).
- `hi`/`lo` are stable between `done` pulses; they never show intermediate values.

## Configuration
- `MULDIV_UNSIGNED_EN` defined:
  - Adds input port `uns` (1 bit), sampled with `start`.
  - `uns`=1 treats `a`/`b` as unsigned (multu/divu) and skips sign correction.
  - `uns`=0 gives the signed behaviour above.
  - Divide-by-zero handling and latency are unchanged.
- `MULDIV_UNSIGNED_EN` not defined: no `uns` port; all operations are signed.

## Test plan
- WIDTH=32, multiply `a`=7, `b`=0xFFFFFFFD (−3) -> after 33 cycles `done` pulses; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- Divide `a`=0xFFFFFFF9 (−7), `b`=2 -> `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1), `div_zero`=0, latency 33.
- Divide `a`=5, `b`=0 after a prior result of `hi`=1, `lo`=2 -> `done` one cycle after `start`; `div_zero`=1; `hi`=1, `lo`=2 unchanged.
- Divide `a`=0x80000000, `b`=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- Multiply started, `start` re-pulsed with new operands at cycle 5, `reset` low at cycle 10:
  - The cycle-5 pulse is ignored.
  - After reset, all outputs are 0 and `busy`=0.
  - A following multiply 3·4 gives `lo`=12, `hi`=0.
- With `MULDIV_UNSIGNED_EN`, WIDTH=8:
  - `uns`=1, multiply 0xFF·0x02 -> `hi`=0x01, `lo`=0xFE after 9 cycles.
  - `uns`=0, same operands -> `hi`=0xFF, `lo`=0xFE.
